// File: rtl/prng_lfsr16.sv
// -----------------------------------------------------------------------------
// prng_lfsr16
//   16-bit maximal-length Fibonacci LFSR pseudo-random number generator with a
//   companion step counter. While reset is held the generator loads the seed
//   on every clock; once reset is released it advances one step per clock with
//   no enable. The counter reports how many steps have been taken since the
//   last reset cycle.
//
// Ports
//   clk   in   1      system clock, all logic on the rising edge
//   rstn  in   1      synchronous reset, active HIGH (1 = reset)
//   seed  in   WIDTH  initial LFSR state, sampled on every clock while rstn==1
//   data  out  WIDTH  current LFSR state (flop output)
//   c     out  WIDTH  step counter, wraps modulo 2^WIDTH (flop output)
// -----------------------------------------------------------------------------
module prng_lfsr16 #(
    parameter int unsigned      WIDTH     = 16,
    parameter logic [WIDTH-1:0] TAPS      = 16'hB400,
    parameter logic [WIDTH-1:0] ZERO_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] c
);

    // Even/odd parity of a word: 1 when an odd number of bits are set.
    function automatic logic parity_of(input logic [WIDTH-1:0] value);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            acc = acc ^ value[i];
        end
        return acc;
    endfunction

    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_cnt;
    logic             w_fb;
    logic             w_seed_zero;
    logic             w_state_zero;
    logic [WIDTH-1:0] w_next_data;

    // Feedback bit and next-state selection for the run phase.
    always_comb begin
        w_fb         = parity_of(r_data & TAPS);
        w_seed_zero  = (seed == {WIDTH{1'b0}});
        w_state_zero = (r_data == {WIDTH{1'b0}});
        if (w_state_zero) begin
            // All-zero state is a lockup point of the LFSR (only reachable
            // through an upset); recover to the substitute seed.
            w_next_data = ZERO_SEED;
        end else begin
            w_next_data = {r_data[WIDTH-2:0], w_fb};
        end
    end

    // LFSR state and step counter: reload while in reset, otherwise advance.
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_data <= w_seed_zero ? ZERO_SEED : seed;
            r_cnt  <= {WIDTH{1'b0}};
        end else begin
            r_data <= w_next_data;
            r_cnt  <= r_cnt + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign data = r_data;
    assign c    = r_cnt;

endmodule

// File: tb/tb_prng_lfsr16.sv
// -----------------------------------------------------------------------------
// tb_prng_lfsr16
//   Self-checking bench for prng_lfsr16. A behavioural reference (polynomial
//   step computed with integer arithmetic and a population count) runs beside
//   the DUT and a compare process checks both outputs on every falling edge
//   once a reset edge has been seen. Directed scenarios pin the reference
//   with hand-computed literals; a full-period walk and a randomized phase
//   exercise the rest.
// -----------------------------------------------------------------------------
module tb_prng_lfsr16;

    localparam logic [15:0] TAPS      = 16'hB400;
    localparam logic [15:0] ZERO_SEED = 16'hACE1;

    logic        clk;
    logic        rstn;
    logic [15:0] seed;
    logic [15:0] data;
    logic [15:0] c;

    int n_checks;
    int n_errors;

    // Reference state.
    logic [15:0] m_data;
    int          m_cnt;
    logic        m_valid;

    bit seen [0:65535];

    prng_lfsr16 dut (
        .clk  (clk),
        .rstn (rstn),
        .seed (seed),
        .data (data),
        .c    (c)
    );

    // 10 time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One step of x^16+x^14+x^13+x^11+1: double the value, drop bit 16 and
    // append the parity of the tapped bits.
    function automatic logic [15:0] model_next(input logic [15:0] s);
        int ones;
        int v;
        if (s == 16'h0000) begin
            return ZERO_SEED;
        end
        ones = $countones(s & TAPS);
        v    = ((int'(s) * 2) % 65536) + (ones % 2);
        return v[15:0];
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model update on each rising edge from the applied inputs.
    always @(posedge clk) begin
        if (rstn === 1'b1) begin
            m_data  <= (seed == 16'h0000) ? ZERO_SEED : seed;
            m_cnt   <= 0;
            m_valid <= 1'b1;
        end else if (m_valid) begin
            m_data <= model_next(m_data);
            m_cnt  <= (m_cnt + 1) % 65536;
        end
    end

    // Every-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("model_data", data, m_data);
            check("model_cnt", c, m_cnt[15:0]);
        end
    end

    // Apply inputs at the falling edge, then return just after the next rise.
    task automatic drive(input logic r, input logic [15:0] s);
        @(negedge clk);
        rstn = r;
        seed = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int bad;
        logic [15:0] rs;
        n_checks = 0;
        n_errors = 0;
        m_valid  = 1'b0;
        m_data   = 16'h0000;
        m_cnt    = 0;
        rstn     = 1'b1;
        seed     = 16'hA16F;

        // Seed load and first three steps.
        drive(1'b1, 16'hA16F);
        drive(1'b1, 16'hA16F);
        drive(1'b1, 16'hA16F);
        check("reset_data", data, 16'hA16F);
        check("reset_cnt", c, 16'h0000);
        drive(1'b0, 16'hA16F);
        check("step1_data", data, 16'h42DE);
        check("step1_cnt", c, 16'h0001);
        drive(1'b0, 16'hA16F);
        check("step2_data", data, 16'h85BC);
        check("step2_cnt", c, 16'h0002);
        drive(1'b0, 16'hA16F);
        check("step3_data", data, 16'h0B78);
        check("step3_cnt", c, 16'h0003);

        // Zero seed substitutes the fixed nonzero state.
        drive(1'b1, 16'h0000);
        check("zseed_data", data, ZERO_SEED);
        check("zseed_cnt", c, 16'h0000);
        drive(1'b0, 16'h0000);
        check("zseed_step_data", data, 16'h59C3);
        check("zseed_step_cnt", c, 16'h0001);

        // Single-cycle reset mid-run.
        repeat (5) drive(1'b0, 16'h5555);
        drive(1'b1, 16'h1234);
        check("midrst_data", data, 16'h1234);
        check("midrst_cnt", c, 16'h0000);
        drive(1'b0, 16'h1234);
        check("midrst_step_data", data, 16'h2469);
        check("midrst_step_cnt", c, 16'h0001);

        // Seed changes: ignored while running, last value wins in reset.
        drive(1'b0, 16'hFFFF);
        drive(1'b0, 16'h0000);
        check("run_seed_ignored_cnt", c, 16'h0003);
        drive(1'b1, 16'h1111);
        drive(1'b1, 16'h2222);
        drive(1'b1, 16'h3333);
        check("last_seed_data", data, 16'h3333);
        check("last_seed_cnt", c, 16'h0000);

        // Full period from 16'hA16F with random seed noise while running.
        drive(1'b1, 16'hA16F);
        for (int i = 0; i < 65536; i++) seen[i] = 1'b0;
        seen[16'hA16F] = 1'b1;
        bad = 0;
        for (int i = 1; i < 65535; i++) begin
            drive(1'b0, 16'($urandom));
            if (data == 16'h0000 || seen[data]) bad++;
            seen[data] = 1'b1;
        end
        check("period_no_repeat", 16'(bad), 16'h0000);
        drive(1'b0, 16'($urandom));
        check("period_data", data, 16'hA16F);
        check("period_cnt", c, 16'hFFFF);
        drive(1'b0, 16'($urandom));
        check("wrap_cnt", c, 16'h0000);
        check("wrap_data", data, 16'h42DE);

        // Randomized resets and seeds.
        for (int i = 0; i < 4000; i++) begin
            rs = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            drive(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0, rs);
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
